// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin sharing of the spi_interface command channel
// (work/len/op/busy) between two requesters. The winner's len/op are latched,
// work is pulsed once, and the busy rise/fall handshake is followed before
// per-client done/err is returned. sel steers the external FIFO muxes.
//
// Optional feature: define SPI_ARB_WDOG_EN to enable a watchdog that aborts
// a transaction (err=1) when busy does not complete within WDOG_CYCLES.
module spi_arbiter #(
    parameter int unsigned LEN_W       = 16,
    parameter int unsigned WDOG_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [LEN_W-1:0] len0,
    input  logic             op0,
    input  logic [LEN_W-1:0] len1,
    input  logic             op1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             err,
    output logic             sel,
    output logic             work,
    output logic [LEN_W-1:0] len,
    output logic             op,
    input  logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_RELEASE
    } state_t;

    state_t           r_state;
    logic             r_last;
    logic [1:0]       r_gnt;
    logic [1:0]       r_done;
    logic             r_err;
    logic             r_sel;
    logic             r_work;
    logic [LEN_W-1:0] r_len;
    logic             r_op;

    logic             w_any;
    logic             w_pick;

`ifdef SPI_ARB_WDOG_EN
    logic [31:0]      r_wdog_cnt;
`else
    logic             w_unused_wdog;
    assign w_unused_wdog = ^WDOG_CYCLES;
`endif

    // Winner selection: a lone requester wins; on contention the client that
    // was not served last wins.
    assign w_any  = |req;
    assign w_pick = (req == 2'b11) ? ~r_last : req[1];

    // Arbitration / handshake FSM with registered outputs. work and done are
    // single-cycle pulses, cleared by default every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_gnt   <= '0;
            r_done  <= '0;
            r_err   <= 1'b0;
            r_sel   <= 1'b0;
            r_work  <= 1'b0;
            r_len   <= '0;
            r_op    <= 1'b0;
`ifdef SPI_ARB_WDOG_EN
            r_wdog_cnt <= '0;
`endif
        end else begin
            r_work <= 1'b0;
            r_done <= '0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_pick ? 2'b10 : 2'b01;
                        r_sel   <= w_pick;
                        r_last  <= w_pick;
                        r_len   <= w_pick ? len1 : len0;
                        r_op    <= w_pick ? op1 : op0;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_len == '0) begin
                        // Zero-length transfers never reach spi_interface.
                        r_done  <= r_gnt;
                        r_err   <= 1'b1;
                        r_gnt   <= '0;
                        r_state <= S_RELEASE;
                    end else begin
                        r_work  <= 1'b1;
                        r_state <= S_WAIT_ACK;
                    end
`ifdef SPI_ARB_WDOG_EN
                    r_wdog_cnt <= '0;
`endif
                end
                S_WAIT_ACK: begin
`ifdef SPI_ARB_WDOG_EN
                    if (r_wdog_cnt == WDOG_CYCLES - 1) begin
                        r_done  <= r_gnt;
                        r_err   <= 1'b1;
                        r_gnt   <= '0;
                        r_state <= S_RELEASE;
                    end else begin
                        r_wdog_cnt <= r_wdog_cnt + 32'd1;
                        if (busy) r_state <= S_WAIT_DONE;
                    end
`else
                    if (busy) r_state <= S_WAIT_DONE;
`endif
                end
                S_WAIT_DONE: begin
`ifdef SPI_ARB_WDOG_EN
                    if (r_wdog_cnt == WDOG_CYCLES - 1) begin
                        r_done  <= r_gnt;
                        r_err   <= 1'b1;
                        r_gnt   <= '0;
                        r_state <= S_RELEASE;
                    end else begin
                        r_wdog_cnt <= r_wdog_cnt + 32'd1;
                        if (!busy) begin
                            r_done  <= r_gnt;
                            r_gnt   <= '0;
                            r_state <= S_RELEASE;
                        end
                    end
`else
                    if (!busy) begin
                        r_done  <= r_gnt;
                        r_gnt   <= '0;
                        r_state <= S_RELEASE;
                    end
`endif
                end
                S_RELEASE: begin
                    // done is visible during this cycle; sel keeps its value.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    assign gnt  = r_gnt;
    assign done = r_done;
    assign err  = r_err;
    assign sel  = r_sel;
    assign work = r_work;
    assign len  = r_len;
    assign op   = r_op;

endmodule
